pll_phase_detector: RTL and testbench
=====================================

// Module: pll_phase_detector
// PURPOSE
//  Digital phase/frequency detector for the PLL loop. Sits directly downstream of the
//  two strobe dividers (reference path and feedback/VCO path). Measures the clock-cycle
//  distance between each divided reference strobe and its paired feedback strobe, and
//  emits a signed phase error per comparison. Also flags cycle slips and reports lock.
// PARAMETERS
//  CNT_WIDTH   16  width of signed phase_err; |error| saturates at ERR_MAX = 2^(CNT_WIDTH-1)-1
//  LOCK_TOL    4   max |phase_err| counted as an in-lock comparison
//  LOCK_COUNT  8   consecutive in-lock comparisons required to assert locked (>=1)
// PORTS
//  clock       in   1          system clock, all logic rising-edge
//  reset       in   1          asynchronous, active-high
//  enable      in   1          0: force IDLE, clear counter, suppress err_valid/slip
//  ref_strobe  in   1          one-cycle pulse from the reference divider
//  fb_strobe   in   1          one-cycle pulse from the feedback divider
//  phase_err   out  CNT_WIDTH  signed; +N = fb lags ref by N cycles, -N = fb leads
//  err_valid   out  1          one-cycle pulse, phase_err valid this cycle
//  slip        out  1          one-cycle pulse with err_valid when the result is a slip/saturation
//  locked      out  1          level, lock indicator
// BEHAVIOUR
//  Reset: phase_err=0, err_valid=0, slip=0, locked=0, state=IDLE, counter=0, lock run=0.
//  States: IDLE, WAIT_FB (ref seen first), WAIT_REF (fb seen first).
//  IDLE: ref&fb same cycle -> err 0, stay IDLE. ref only -> WAIT_FB, cnt=1.
//    fb only -> WAIT_REF, cnt=1. Neither -> stay.
//  WAIT_FB: fb -> err=+cnt, -> IDLE (or -> WAIT_FB, cnt=1 if ref also present this cycle).
//    ref again without fb -> slip: err=+ERR_MAX, slip=1, stay WAIT_FB, cnt=1.
//    Otherwise cnt increments; when cnt reaches ERR_MAX -> err=+ERR_MAX, slip=1, -> IDLE.
//  WAIT_REF: mirror image with negative sign (-cnt, -ERR_MAX).
//  Results register on the clock edge that samples the closing strobe, so err_valid
//    is high the cycle after that strobe (latency 1).
//    Example: ref sampled at edge k, fb at edge k+3 -> err_valid during cycle k+4, phase_err=+3.
//  phase_err holds its last value between err_valid pulses. err_valid and slip are 0
//    in all other cycles.
//  Counter never wraps. Saturation at ERR_MAX is the timeout, so -2^(CNT_WIDTH-1) is
//    never produced.
//  Lock: on each err_valid with slip=0 and |phase_err|<=LOCK_TOL, run=min(run+1,LOCK_COUNT).
//    Any other err_valid clears run. locked = (run==LOCK_COUNT), registered. Lock updates
//    the cycle after err_valid.
//  enable low: state=IDLE, cnt=0, run=0, locked=0. Strobes are ignored. phase_err holds.
//    Re-enable starts cleanly from IDLE.
//  Reset mid-measurement aborts it. No err_valid is produced for the partial pair.
// STRUCTURE
//  Shared package pll_pkg: state encoding (IDLE/WAIT_FB/WAIT_REF) and an ERR_MAX helper
//    function of CNT_WIDTH, so the loop filter can reuse them.
//  One sub-module, pll_lock_detect: consumes err_valid/slip/phase_err and owns run/locked.
//  Top level holds the FSM, the counter and the output registers.
// TESTING  (CNT_WIDTH=16, LOCK_TOL=4, LOCK_COUNT=8)
//  1. ref at cycle 10, fb at cycle 13 -> err_valid during cycle 14, phase_err=+3, slip=0.
//  2. fb at cycle 20, ref at cycle 25 -> phase_err=-5. ref and fb both at cycle 30 ->
//     phase_err=0, err_valid one cycle later.
//  3. ref at 0, ref at 50, no fb -> err_valid at 51 with phase_err=+32767, slip=1,
//     state WAIT_FB. Then fb at 52 -> phase_err=+2.
//  4. ref only, no fb for 40000 cycles -> one err_valid with +32767, slip=1 after 32767
//     counts, then IDLE with no further pulses.
//  5. 8 pairs at +2 -> locked rises the cycle after the 8th err_valid. One pair at +9
//     -> locked falls. 7 pairs at 0 -> still 0. 8th pair -> 1.
//  6. reset pulse 2 cycles after a ref strobe, and enable low mid-wait -> no err_valid,
//     locked=0, then a clean pair (ref 5, fb 6) yields +1.

Source files
------------

// File: rtl/pll_pkg.sv
// Shared PLL definitions: phase-detector state encoding and the saturation limit
// helper, kept here so the loop filter can use the same values.
package pll_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_FB  = 2'd1,
      WAIT_REF = 2'd2
   } pd_state_t;

   // Largest positive magnitude of a signed error of the given width (width 2..31).
   function automatic int err_max(input int cnt_width);
      return (1 << (cnt_width - 1)) - 1;
   endfunction

endpackage

// File: rtl/pll_lock_detect.sv
// Lock qualifier: counts consecutive small, slip-free phase errors and asserts
// locked once the run reaches lock_count.
module pll_lock_detect
   import pll_pkg::*;
#(
   parameter int CNT_WIDTH  = 16,
   parameter int LOCK_TOL   = 4,
   parameter int LOCK_COUNT = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        err_valid,
   input  logic                        slip,
   input  logic signed [CNT_WIDTH-1:0] phase_err,
   output logic                        locked
);

   localparam int RUN_W = $clog2(LOCK_COUNT + 1);
   localparam logic [RUN_W-1:0]     RUN_FULL = RUN_W'(LOCK_COUNT);
   localparam logic [CNT_WIDTH-1:0] TOL      = CNT_WIDTH'(LOCK_TOL);

   logic [RUN_W-1:0]     run;
   logic [RUN_W-1:0]     run_next;
   logic [CNT_WIDTH-1:0] mag;

   // The detector never emits the most negative value, so negation cannot overflow.
   assign mag = phase_err[CNT_WIDTH-1] ? $unsigned(-phase_err) : $unsigned(phase_err);

   always_comb begin
      run_next = run;
      if (err_valid) begin
         if (!slip && (mag <= TOL)) begin
            run_next = (run == RUN_FULL) ? run : run + 1'b1;
         end else begin
            run_next = '0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         run    <= '0;
         locked <= 1'b0;
      end else if (clear) begin
         run    <= '0;
         locked <= 1'b0;
      end else begin
         run    <= run_next;
         locked <= (run_next == RUN_FULL);
      end
   end

endmodule

// File: rtl/pll_phase_detector.sv
// Digital phase/frequency detector: measures the cycle distance between paired
// reference and feedback strobes and reports a signed, saturating phase error.
module pll_phase_detector
   import pll_pkg::*;
#(
   parameter int CNT_WIDTH  = 16,
   parameter int LOCK_TOL   = 4,
   parameter int LOCK_COUNT = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        ref_strobe,
   input  logic                        fb_strobe,
   output logic signed [CNT_WIDTH-1:0] phase_err,
   output logic                        err_valid,
   output logic                        slip,
   output logic                        locked
);

   localparam int ERR_MAX_I = err_max(CNT_WIDTH);
   localparam logic signed [CNT_WIDTH-1:0] ERR_MAX_S = CNT_WIDTH'(ERR_MAX_I);
   localparam logic [CNT_WIDTH-1:0]        CNT_LAST  = CNT_WIDTH'(ERR_MAX_I - 1);
   localparam logic [CNT_WIDTH-1:0]        CNT_ONE   = CNT_WIDTH'(1);

   pd_state_t                   state;
   pd_state_t                   state_next;
   logic [CNT_WIDTH-1:0]        cnt;
   logic [CNT_WIDTH-1:0]        cnt_next;
   logic                        err_load;
   logic signed [CNT_WIDTH-1:0] err_next;
   logic                        slip_next;
   logic                        lock_clear;

   // A count that would reach ERR_MAX is the timeout: it reports saturation and gives up.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      err_load   = 1'b0;
      err_next   = '0;
      slip_next  = 1'b0;
      if (!enable) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (ref_strobe && fb_strobe) begin
                  err_load = 1'b1;
               end else if (ref_strobe) begin
                  state_next = WAIT_FB;
                  cnt_next   = CNT_ONE;
               end else if (fb_strobe) begin
                  state_next = WAIT_REF;
                  cnt_next   = CNT_ONE;
               end
            end
            WAIT_FB: begin
               if (fb_strobe) begin
                  err_load = 1'b1;
                  err_next = $signed(cnt);
                  if (ref_strobe) begin
                     cnt_next = CNT_ONE;
                  end else begin
                     state_next = IDLE;
                     cnt_next   = '0;
                  end
               end else if (ref_strobe) begin
                  err_load  = 1'b1;
                  err_next  = ERR_MAX_S;
                  slip_next = 1'b1;
                  cnt_next  = CNT_ONE;
               end else if (cnt == CNT_LAST) begin
                  err_load   = 1'b1;
                  err_next   = ERR_MAX_S;
                  slip_next  = 1'b1;
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
            WAIT_REF: begin
               if (ref_strobe) begin
                  err_load = 1'b1;
                  err_next = -$signed(cnt);
                  if (fb_strobe) begin
                     cnt_next = CNT_ONE;
                  end else begin
                     state_next = IDLE;
                     cnt_next   = '0;
                  end
               end else if (fb_strobe) begin
                  err_load  = 1'b1;
                  err_next  = -ERR_MAX_S;
                  slip_next = 1'b1;
                  cnt_next  = CNT_ONE;
               end else if (cnt == CNT_LAST) begin
                  err_load   = 1'b1;
                  err_next   = -ERR_MAX_S;
                  slip_next  = 1'b1;
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         phase_err <= '0;
         err_valid <= 1'b0;
         slip      <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         err_valid <= err_load;
         slip      <= slip_next;
         if (err_load) begin
            phase_err <= err_next;
         end
      end
   end

   assign lock_clear = ~enable;

   pll_lock_detect #(
      .CNT_WIDTH  (CNT_WIDTH),
      .LOCK_TOL   (LOCK_TOL),
      .LOCK_COUNT (LOCK_COUNT)
   ) u_lock_detect (
      .clock     (clock),
      .reset     (reset),
      .clear     (lock_clear),
      .err_valid (err_valid),
      .slip      (slip),
      .phase_err (phase_err),
      .locked    (locked)
   );

endmodule

// File: tb/tb_pll_phase_detector.sv
// Directed bench for pll_phase_detector: pairing, slips, saturation timeout, lock
// qualification, enable gating and asynchronous reset.
module tb_pll_phase_detector;

   logic               clock = 1'b0;
   logic               reset;
   logic               enable;
   logic               ref_strobe;
   logic               fb_strobe;
   logic signed [15:0] phase_err;
   logic               err_valid;
   logic               slip;
   logic               locked;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   pll_phase_detector #(
      .CNT_WIDTH  (16),
      .LOCK_TOL   (4),
      .LOCK_COUNT (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .ref_strobe (ref_strobe),
      .fb_strobe  (fb_strobe),
      .phase_err  (phase_err),
      .err_valid  (err_valid),
      .slip       (slip),
      .locked     (locked)
   );

   task automatic check_output(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive strobes for one edge, then sample the registered results 1 time unit later.
   task automatic apply_stimulus(input logic r, input logic f);
      ref_strobe = r;
      fb_strobe  = f;
      @(posedge clock);
      #1;
      ref_strobe = 1'b0;
      fb_strobe  = 1'b0;
   endtask

   task automatic idle_quiet(input int n, input string tag);
      int pulses;
      pulses = 0;
      repeat (n) begin
         apply_stimulus(1'b0, 1'b0);
         if (err_valid !== 1'b0) pulses++;
      end
      check_output(tag, pulses, 0);
   endtask

   task automatic check_pulse(input string tag, input int exp_err, input logic exp_slip);
      check_output({tag, "_valid"}, err_valid, 1);
      check_output({tag, "_err"}, phase_err, exp_err);
      check_output({tag, "_slip"}, slip, exp_slip);
   endtask

   initial begin
      int pulses;
      int first_idx;
      int first_err;
      int first_slip;

      reset      = 1'b1;
      enable     = 1'b1;
      ref_strobe = 1'b0;
      fb_strobe  = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_output("rst_err", phase_err, 0);
      check_output("rst_valid", err_valid, 0);
      check_output("rst_slip", slip, 0);
      check_output("rst_locked", locked, 0);
      reset = 1'b0;
      idle_quiet(3, "rst_quiet");

      // fb lags ref by 3
      apply_stimulus(1'b1, 1'b0);
      idle_quiet(2, "t1_gap");
      apply_stimulus(1'b0, 1'b1);
      check_pulse("t1", 3, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      check_output("t1_valid_drop", err_valid, 0);
      check_output("t1_hold", phase_err, 3);

      // fb leads ref by 5, then coincident strobes
      apply_stimulus(1'b0, 1'b1);
      idle_quiet(4, "t2_gap");
      apply_stimulus(1'b1, 1'b0);
      check_pulse("t2_lead", -5, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b1);
      check_pulse("t2_zero", 0, 1'b0);

      // second ref without fb is a slip, measurement restarts from that ref
      apply_stimulus(1'b1, 1'b0);
      idle_quiet(49, "t3_gap");
      apply_stimulus(1'b1, 1'b0);
      check_pulse("t3_slip", 32767, 1'b1);
      apply_stimulus(1'b0, 1'b0);
      check_output("t3_valid_drop", err_valid, 0);
      check_output("t3_slip_drop", slip, 0);
      apply_stimulus(1'b0, 1'b1);
      check_pulse("t3_after", 2, 1'b0);

      // saturation timeout with no fb at all
      apply_stimulus(1'b1, 1'b0);
      pulses     = 0;
      first_idx  = -1;
      first_err  = 0;
      first_slip = 0;
      for (int j = 1; j <= 40000; j++) begin
         apply_stimulus(1'b0, 1'b0);
         if (err_valid === 1'b1) begin
            pulses++;
            if (first_idx < 0) begin
               first_idx  = j;
               first_err  = int'(phase_err);
               first_slip = int'(slip);
            end
         end
      end
      check_output("t4_pulses", pulses, 1);
      check_output("t4_index", first_idx, 32766);
      check_output("t4_err", first_err, 32767);
      check_output("t4_slip", first_slip, 1);
      apply_stimulus(1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0);
      check_pulse("t4_idle_after", -2, 1'b0);

      // clear the lock run with a large error, then qualify lock
      apply_stimulus(1'b1, 1'b0);
      idle_quiet(8, "t5_gap9");
      apply_stimulus(1'b0, 1'b1);
      check_pulse("t5_big", 9, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, 1'b0);
         apply_stimulus(1'b0, 1'b0);
         apply_stimulus(1'b0, 1'b1);
         check_output("t5_pair_err", phase_err, 2);
         apply_stimulus(1'b0, 1'b0);
         check_output($sformatf("t5_lock_%0d", i), locked, (i == 7) ? 1 : 0);
      end
      apply_stimulus(1'b1, 1'b0);
      idle_quiet(8, "t5_gap9b");
      apply_stimulus(1'b0, 1'b1);
      check_pulse("t5_unlock_pair", 9, 1'b0);
      check_output("t5_lock_hold", locked, 1);
      apply_stimulus(1'b0, 1'b0);
      check_output("t5_lock_fall", locked, 0);
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, 1'b1);
         check_pulse("t5_zero", 0, 1'b0);
         apply_stimulus(1'b0, 1'b0);
         check_output($sformatf("t5_relock_%0d", i), locked, (i == 7) ? 1 : 0);
      end

      // enable low mid-wait aborts and drops lock
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      enable = 1'b0;
      apply_stimulus(1'b0, 1'b1);
      check_output("t6_en_valid", err_valid, 0);
      check_output("t6_en_locked", locked, 0);
      idle_quiet(2, "t6_en_quiet");
      check_output("t6_en_hold", phase_err, 0);
      enable = 1'b1;
      idle_quiet(3, "t6_reen_quiet");
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b1);
      check_pulse("t6_en_pair", 1, 1'b0);

      // asynchronous reset two cycles after a ref strobe
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #2;
      check_output("t6_rst_err", phase_err, 0);
      check_output("t6_rst_valid", err_valid, 0);
      check_output("t6_rst_locked", locked, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      idle_quiet(4, "t6_rst_quiet");
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b1);
      check_pulse("t6_clean", 1, 1'b0);
      check_output("t6_locked_low", locked, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
